// File: rtl/bp_be_fp_pkg.sv
// rtl/bp_be_fp_pkg.sv - shared FP widths, recoded bias constants and special-class codes
package bp_be_fp_pkg;

  localparam int DWORD_W      = 64;
  localparam int DP_REC_W     = 65;
  localparam int DP_EXP_W     = 11;
  localparam int DP_SIG_W     = 53;
  localparam int SP_EXP_W     = 8;
  localparam int SP_SIG_W     = 24;
  localparam int DP_REC_EXP_W = DP_EXP_W + 1;
  localparam int SP_REC_EXP_W = SP_EXP_W + 1;

  // Recoded exponent of 1.0 in each format, and the offset that moves a
  // DP recoded exponent into SP recoded range.
  localparam logic [DP_REC_EXP_W-1:0] DP_REC_ONE    = 12'h800;
  localparam logic [SP_REC_EXP_W-1:0] SP_REC_ONE    = 9'h100;
  localparam logic [DP_REC_EXP_W-1:0] REC_NARROW_OFS = 12'd1792;

  // Special classes live in the top three bits of the recoded exponent.
  typedef enum logic [2:0] {
    REC_CLS_ZERO = 3'b000,
    REC_CLS_INF  = 3'b110,
    REC_CLS_NAN  = 3'b111
  } rec_cls_e;

  function automatic logic is_rec_special(input logic [2:0] cls);
    return (cls == REC_CLS_ZERO) || (cls == REC_CLS_INF) || (cls == REC_CLS_NAN);
  endfunction

endpackage

// File: rtl/bp_be_recfn_to_fn.sv
// rtl/bp_be_recfn_to_fn.sv - combinational recoded-to-IEEE decoder for one format
module bp_be_recfn_to_fn
  import bp_be_fp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int SIG_W = 53
) (
  input  logic                   i_sign,
  input  logic [EXP_W:0]         i_exp,
  input  logic [SIG_W-2:0]       i_frac,
  output logic [EXP_W+SIG_W-1:0] o_raw
);

  // Smallest recoded exponent that still maps to a normal number; one less
  // than it is the bias removed from normals.
  localparam int MIN_NORM = (1 << (EXP_W - 1)) + 2;
  localparam logic [EXP_W:0] MIN_NORM_C = (EXP_W + 1)'(MIN_NORM);
  localparam logic [EXP_W:0] BIAS_C     = (EXP_W + 1)'(MIN_NORM - 1);

  logic [2:0]       w_cls;
  logic [EXP_W:0]   w_shift;
  logic [EXP_W-1:0] w_exp;
  logic [SIG_W-2:0] w_frac;

  assign w_cls   = i_exp[EXP_W -: 3];
  assign w_shift = MIN_NORM_C - i_exp;

  // Decode class, then normal vs subnormal for finite values; shifts past
  // the significand width fall out as zero.
  always_comb begin
    w_exp  = '0;
    w_frac = '0;
    case (w_cls)
      REC_CLS_ZERO: begin
        w_exp  = '0;
        w_frac = '0;
      end
      REC_CLS_INF: begin
        w_exp  = '1;
        w_frac = '0;
      end
      REC_CLS_NAN: begin
        w_exp  = '1;
        w_frac = i_frac;
      end
      default: begin
        if (i_exp >= MIN_NORM_C) begin
          w_exp  = EXP_W'(i_exp - BIAS_C);
          w_frac = i_frac;
        end else begin
          w_exp  = '0;
          w_frac = (SIG_W - 1)'({1'b1, i_frac} >> w_shift);
        end
      end
    endcase
  end

  assign o_raw = {i_sign, w_exp, w_frac};

endmodule

// File: rtl/bp_be_rec_to_raw_fp.sv
// rtl/bp_be_rec_to_raw_fp.sv - registered recoded-DP to IEEE raw (DP or NaN-boxed SP)
module bp_be_rec_to_raw_fp
  import bp_be_fp_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [DP_REC_W-1:0] rec_i,
  input  logic                raw_sp_not_dp_i,
  output logic                v_o,
  output logic [DWORD_W-1:0]  raw_o
);

  logic                    w_sign;
  logic [DP_REC_EXP_W-1:0] w_exp;
  logic [DP_SIG_W-2:0]     w_frac;
  logic [SP_REC_EXP_W-1:0] w_sp_exp;
  logic [SP_SIG_W-2:0]     w_sp_frac;
  logic [DWORD_W-1:0]      w_dp_raw;
  logic [31:0]             w_sp_raw;
  logic [DWORD_W-1:0]      w_raw;
  logic                    r_v;
  logic [DWORD_W-1:0]      r_raw;

  assign w_sign = rec_i[64];
  assign w_exp  = rec_i[63:52];
  assign w_frac = rec_i[51:0];

  bp_be_recfn_to_fn #(
    .EXP_W(DP_EXP_W),
    .SIG_W(DP_SIG_W)
  ) u_dp (
    .i_sign (w_sign),
    .i_exp  (w_exp),
    .i_frac (w_frac),
    .o_raw  (w_dp_raw)
  );

  // Narrow to SP recoded form: specials only need their class bits, finite
  // values are rebiased. Low fraction bits are zero for exact SP values.
  always_comb begin
    w_sp_exp = 9'(w_exp - REC_NARROW_OFS);
    if (is_rec_special(w_exp[11:9])) begin
      w_sp_exp = {w_exp[11:9], 6'b0};
    end
  end

  assign w_sp_frac = w_frac[51:29];

  bp_be_recfn_to_fn #(
    .EXP_W(SP_EXP_W),
    .SIG_W(SP_SIG_W)
  ) u_sp (
    .i_sign (w_sign),
    .i_exp  (w_sp_exp),
    .i_frac (w_sp_frac),
    .o_raw  (w_sp_raw)
  );

  assign w_raw = raw_sp_not_dp_i ? {32'hFFFF_FFFF, w_sp_raw} : w_dp_raw;

  // Output register: reset wins, valid follows v_i, data holds when idle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_v   <= 1'b0;
      r_raw <= '0;
    end else begin
      r_v <= v_i;
      if (v_i) begin
        r_raw <= w_raw;
      end
    end
  end

  assign v_o   = r_v;
  assign raw_o = r_raw;

endmodule

// File: tb/tb_bp_be_rec_to_raw_fp.sv
// tb/tb_bp_be_rec_to_raw_fp.sv - directed self-checking bench for bp_be_rec_to_raw_fp
module tb_bp_be_rec_to_raw_fp;

  logic        clk_i;
  logic        reset_n_i;
  logic        v_i;
  logic [64:0] rec_i;
  logic        raw_sp_not_dp_i;
  logic        v_o;
  logic [63:0] raw_o;

  int n_cmp = 0;
  int n_err = 0;

  bp_be_rec_to_raw_fp dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .v_i             (v_i),
    .rec_i           (rec_i),
    .raw_sp_not_dp_i (raw_sp_not_dp_i),
    .v_o             (v_o),
    .raw_o           (raw_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [64:0] mk_rec(input logic s, input logic [11:0] e, input logic [51:0] f);
    return {s, e, f};
  endfunction

  task automatic apply(input string tag, input logic [64:0] rec, input logic sp, input logic [63:0] exp_raw);
    @(negedge clk_i);
    v_i             = 1'b1;
    rec_i           = rec;
    raw_sp_not_dp_i = sp;
    @(posedge clk_i);
    #1;
    check_val({tag, "_v"}, {63'b0, v_o}, 64'd1);
    check_val(tag, raw_o, exp_raw);
    @(negedge clk_i);
    v_i = 1'b0;
  endtask

  logic [64:0] s_rec [3];
  logic        s_sp  [3];
  logic [63:0] s_exp [3];

  initial begin
    reset_n_i       = 1'b0;
    v_i             = 1'b0;
    rec_i           = '0;
    raw_sp_not_dp_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("reset_v", {63'b0, v_o}, 64'd0);
    check_val("reset_raw", raw_o, 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    apply("dp_one",     mk_rec(1'b0, 12'h800, 52'h0), 1'b0, 64'h3FF0_0000_0000_0000);
    apply("sp_one",     mk_rec(1'b0, 12'h800, 52'h0), 1'b1, 64'hFFFF_FFFF_3F80_0000);
    apply("sp_ninf",    mk_rec(1'b1, 12'hC00, 52'h0), 1'b1, 64'hFFFF_FFFF_FF80_0000);
    apply("dp_zero",    mk_rec(1'b0, 12'h000, 52'h0), 1'b0, 64'h0);
    apply("dp_nzero",   mk_rec(1'b1, 12'h000, 52'h0), 1'b0, 64'h8000_0000_0000_0000);
    apply("dp_ninf",    mk_rec(1'b1, 12'hC00, 52'h0), 1'b0, 64'hFFF0_0000_0000_0000);
    apply("dp_qnan",    mk_rec(1'b0, 12'hE00, 52'h8_0000_0000_0000), 1'b0, 64'h7FF8_0000_0000_0000);
    apply("dp_sub_min", mk_rec(1'b0, 12'h3CE, 52'h0), 1'b0, 64'h0000_0000_0000_0001);
    apply("dp_sub_max", mk_rec(1'b0, 12'h401, 52'h0), 1'b0, 64'h0008_0000_0000_0000);
    apply("dp_shift53", mk_rec(1'b0, 12'h3CD, 52'hF_FFFF_FFFF_FFFF), 1'b0, 64'h0);
    apply("dp_2p5",     mk_rec(1'b0, 12'h801, 52'h4_0000_0000_0000), 1'b0, 64'h4004_0000_0000_0000);
    apply("sp_qnan",    mk_rec(1'b0, 12'hE00, 52'h8_0000_0000_0000), 1'b1, 64'hFFFF_FFFF_7FC0_0000);
    apply("sp_sub_min", mk_rec(1'b0, 12'h76B, 52'h0), 1'b1, 64'hFFFF_FFFF_0000_0001);
    apply("sp_m1p5",    mk_rec(1'b1, 12'h800, 52'h8_0000_0000_0000), 1'b1, 64'hFFFF_FFFF_BFC0_0000);

    s_rec[0] = mk_rec(1'b0, 12'h800, 52'h0); s_sp[0] = 1'b0; s_exp[0] = 64'h3FF0_0000_0000_0000;
    s_rec[1] = mk_rec(1'b1, 12'hC00, 52'h0); s_sp[1] = 1'b1; s_exp[1] = 64'hFFFF_FFFF_FF80_0000;
    s_rec[2] = mk_rec(1'b0, 12'h401, 52'h0); s_sp[2] = 1'b0; s_exp[2] = 64'h0008_0000_0000_0000;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      v_i             = 1'b1;
      rec_i           = s_rec[i];
      raw_sp_not_dp_i = s_sp[i];
      @(posedge clk_i);
      #1;
      check_val($sformatf("stream%0d_v", i), {63'b0, v_o}, 64'd1);
      check_val($sformatf("stream%0d_raw", i), raw_o, s_exp[i]);
      @(negedge clk_i);
    end
    v_i   = 1'b0;
    rec_i = mk_rec(1'b0, 12'h800, 52'h0);
    @(posedge clk_i);
    #1;
    check_val("idle_v", {63'b0, v_o}, 64'd0);
    check_val("idle_hold", raw_o, 64'h0008_0000_0000_0000);
    @(posedge clk_i);
    #1;
    check_val("idle_hold2", raw_o, 64'h0008_0000_0000_0000);

    @(negedge clk_i);
    reset_n_i = 1'b0;
    v_i       = 1'b1;
    rec_i     = mk_rec(1'b0, 12'h800, 52'h0);
    @(posedge clk_i);
    #1;
    check_val("rst_drop_v", {63'b0, v_o}, 64'd0);
    check_val("rst_drop_raw", raw_o, 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    v_i       = 1'b0;
    @(posedge clk_i);
    #1;
    check_val("post_rst_v", {63'b0, v_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
